// File: rtl/i2f_share_arbiter_if.sv
// Requester-side bus of the shared int-to-float arbiter.
// master: requesters drive req_valid/req_data and consume req_ready and the responses.
// slave:  the arbiter grants via req_ready and returns resp_valid/resp_data/resp_id.
interface i2f_share_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [31:0]           resp_data;
  logic [ID_W-1:0]       resp_id;

  modport master (
    output req_valid, req_data,
    input  req_ready, resp_valid, resp_data, resp_id
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, resp_valid, resp_data, resp_id
  );
endinterface

// File: rtl/i2f_share_arbiter.sv
// Shares one pipelined int-to-fp32 converter among NUM_REQ requesters.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   req_bus      - requester handshake and response bus (slave side)
//   drain        - blocks new grants while in-flight operations finish
//   conv_in      - registered converter input_a (0 in idle slots)
//   conv_out     - converter output_z, CONV_LAT edges behind conv_in
//   busy         - any operation in flight
//   inflight_cnt - number of operations in flight
module i2f_share_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned CONV_LAT = 6,
  parameter int unsigned ID_W     = 2
) (
  input  logic                clk,
  input  logic                rst,
  i2f_share_arbiter_if.slave  req_bus,
  input  logic                drain,
  output logic [31:0]         conv_in,
  input  logic [31:0]         conv_out,
  output logic                busy,
  output logic [3:0]          inflight_cnt
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  logic [ID_W-1:0]                rr_ptr;
  logic [ID_W-1:0]                cand;
  logic [ID_W-1:0]                grant_id;
  logic [ID_W-1:0]                issue_id;
  logic                           grant_found;
  logic                           fire;
  logic [NUM_REQ-1:0]             grant;
  logic [CONV_LAT:0]              tag_v;
  logic [CONV_LAT:0][ID_W-1:0]    tag_id;

  // Round-robin search starting at rr_ptr, wrapping at NUM_REQ
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    grant       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!grant_found && req_bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
    fire     = grant_found & ~drain & ~rst;
    issue_id = fire ? grant_id : '0;
    if (fire) begin
      grant[grant_id] = 1'b1;
    end
  end

  assign req_bus.req_ready = grant;

  // Issue register, tag pipeline, pointer and occupancy counter
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr       <= '0;
      conv_in      <= '0;
      tag_v        <= '0;
      tag_id       <= '0;
      inflight_cnt <= '0;
    end else begin
      if (fire) begin
        rr_ptr  <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        conv_in <= req_bus.req_data[32'(grant_id) * DATA_W +: DATA_W];
      end else begin
        conv_in <= '0;
      end
      tag_v  <= {tag_v[CONV_LAT-1:0], fire};
      tag_id <= {tag_id[CONV_LAT-1:0], issue_id};
      case ({fire, tag_v[CONV_LAT]})
        2'b10:   inflight_cnt <= inflight_cnt + CNT_W'(1);
        2'b01:   inflight_cnt <= inflight_cnt - CNT_W'(1);
        default: inflight_cnt <= inflight_cnt;
      endcase
    end
  end

  // Response is taken straight from the last tag stage; no backpressure
  always_comb begin
    req_bus.resp_valid = '0;
    req_bus.resp_data  = '0;
    req_bus.resp_id    = tag_id[CONV_LAT];
    if (tag_v[CONV_LAT]) begin
      req_bus.resp_valid[tag_id[CONV_LAT]] = 1'b1;
      req_bus.resp_data                    = conv_out;
    end
  end

  assign busy = (inflight_cnt != '0);
endmodule

// File: tb/tb_i2f_share_arbiter.sv
// Bench for i2f_share_arbiter: behavioural converter, scoreboard of grants,
// table of isolated conversions, and sequences for contention, fairness,
// drain and reset mid-flight.
module tb_i2f_share_arbiter;
  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned CONV_LAT = 6;
  localparam int unsigned ID_W     = 2;

  typedef struct {
    int          id;
    logic [31:0] exp;
    int          cyc;
  } sb_t;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        drain = 1'b0;
  logic [31:0] conv_in;
  logic [31:0] conv_out;
  logic        busy;
  logic [3:0]  inflight_cnt;

  int n_pass = 0;
  int n_chk = 0;
  int n_stray = 0;
  int cyc = 0;
  int last_grant_cyc = 0;
  int cnt_max = 0;

  logic [NUM_REQ-1:0] last_hs;
  logic [31:0]        exp_fp [NUM_REQ];
  sb_t                sb [$];
  int                 glog [$];
  vec_t               tv [9];

  i2f_share_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  i2f_share_arbiter #(
    .NUM_REQ (NUM_REQ),
    .CONV_LAT(CONV_LAT),
    .ID_W    (ID_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_bus     (bus),
    .drain       (drain),
    .conv_in     (conv_in),
    .conv_out    (conv_out),
    .busy        (busy),
    .inflight_cnt(inflight_cnt)
  );

  always #5 clk = ~clk;

  // Reference signed int32 -> fp32, round to nearest even
  function automatic logic [31:0] i2f(input logic [31:0] x);
    logic        s;
    logic [31:0] m;
    logic [31:0] mant;
    logic [31:0] rem;
    logic [31:0] half;
    logic [7:0]  e;
    int          p;
    int          sh;
    if (x == 32'd0) return 32'd0;
    s = x[31];
    m = s ? (~x + 32'd1) : x;
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    e = 8'(127 + p);
    if (p <= 23) begin
      mant = m << (23 - p);
    end else begin
      sh   = p - 23;
      mant = m >> sh;
      rem  = m & ((32'd1 << sh) - 32'd1);
      half = 32'd1 << (sh - 1);
      if (rem > half || (rem == half && mant[0])) mant = mant + 32'd1;
      if (mant[24]) begin
        mant = mant >> 1;
        e    = e + 8'd1;
      end
    end
    return {s, e, mant[22:0]};
  endfunction

  // Converter model: CONV_LAT-stage pipeline, shares rst
  logic [31:0] conv_pipe [CONV_LAT];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(CONV_LAT); k++) conv_pipe[k] <= 32'd0;
    end else begin
      conv_pipe[0] <= i2f(conv_in);
      for (int k = 1; k < int'(CONV_LAT); k++) conv_pipe[k] <= conv_pipe[k-1];
    end
  end
  assign conv_out = conv_pipe[CONV_LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int i, input logic [31:0] d);
    bus.req_data[32*i +: 32] = d;
    exp_fp[i] = i2f(d);
  endtask

  task automatic run(input logic [NUM_REQ-1:0] mask, input int n);
    for (int c = 0; c < n; c++) begin
      bus.req_valid = mask;
      step();
      for (int i = 0; i < int'(NUM_REQ); i++) if (last_hs[i]) load(i, $urandom);
    end
    bus.req_valid = '0;
  endtask

  task automatic idle(input int n);
    bus.req_valid = '0;
    repeat (n) step();
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor: occupancy, grants into scoreboard, responses out of it
  initial begin
    logic [NUM_REQ-1:0] hs;
    int  gid;
    sb_t e;
    forever begin
      @(negedge clk);
      hs      = bus.req_valid & bus.req_ready;
      last_hs = hs;
      chk("inflight_cnt", 32'(inflight_cnt), 32'(sb.size()));
      chk("busy", 32'(busy), 32'(sb.size() != 0));
      if (int'(inflight_cnt) > cnt_max) cnt_max = int'(inflight_cnt);
      if (drain) chk("ready_during_drain", 32'(bus.req_ready), 32'd0);
      if (hs != '0) begin
        gid = 0;
        for (int i = 0; i < int'(NUM_REQ); i++) if (hs[i]) gid = i;
        chk("grant_onehot", 32'($countones(bus.req_ready)), 32'd1);
        sb.push_back('{id: gid, exp: exp_fp[gid], cyc: cyc});
        glog.push_back(gid);
        last_grant_cyc = cyc;
      end
      if (bus.resp_valid != '0) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_stray++;
          $display("FAIL stray_resp: resp_valid=%b with nothing in flight (cycle %0d)",
                   bus.resp_valid, cyc);
        end else begin
          e = sb.pop_front();
          chk("resp_valid", 32'(bus.resp_valid), 32'd1 << e.id);
          chk("resp_id", 32'(bus.resp_id), 32'(e.id));
          chk("resp_data", bus.resp_data, e.exp);
          chk("resp_latency", 32'(cyc - e.cyc), 32'(CONV_LAT + 1));
        end
      end else begin
        chk("resp_data_idle", bus.resp_data, 32'd0);
      end
      if (rst) sb.delete();
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic done;
    int   stray_before;

    tv[0] = '{id: 2, data: 32'h0000_0001, exp: 32'h3F80_0000};
    tv[1] = '{id: 0, data: 32'hFFFF_FFFF, exp: 32'hBF80_0000};
    tv[2] = '{id: 0, data: 32'h0000_0000, exp: 32'h0000_0000};
    tv[3] = '{id: 0, data: 32'h0000_0010, exp: 32'h4180_0000};
    tv[4] = '{id: 1, data: 32'h8000_0000, exp: 32'hCF00_0000};
    tv[5] = '{id: 1, data: 32'h7FFF_FFFF, exp: 32'h4F00_0000};
    tv[6] = '{id: 2, data: 32'hFFFF_FFFE, exp: 32'hC000_0000};
    tv[7] = '{id: 3, data: 32'h0100_0001, exp: 32'h4B80_0000};
    tv[8] = '{id: 3, data: 32'h0000_0003, exp: 32'h4040_0000};

    for (int i = 0; i < int'(NUM_REQ); i++) load(i, 32'(i + 5));
    bus.req_valid = '1;
    rst = 1'b1;
    repeat (3) step();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_conv_in", conv_in, 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'd0);
    chk("rst_resp_id", 32'(bus.resp_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_inflight_cnt", 32'(inflight_cnt), 32'd0);
    bus.req_valid = '0;
    rst = 1'b0;
    step();

    // Isolated conversions
    for (int v = 0; v < 9; v++) begin
      bus.req_valid = '0;
      bus.req_valid[tv[v].id] = 1'b1;
      bus.req_data[32*tv[v].id +: 32] = tv[v].data;
      exp_fp[tv[v].id] = tv[v].exp;
      #1;
      chk("single_ready", 32'(bus.req_ready), 32'd1 << tv[v].id);
      step();
      idle(9);
    end

    // Full contention: pointer is 0 after the last grant to requester 3
    glog.delete();
    cnt_max = 0;
    run('1, 12);
    chk("contention_count", 32'(glog.size()), 32'd12);
    for (int k = 0; k < glog.size(); k++) chk("contention_order", 32'(glog[k]), 32'(k % 4));
    chk("cnt_saturates", 32'(cnt_max), 32'(CONV_LAT + 1));

    // Fairness and wrap: last grant was 3, only 1 and 3 requesting
    glog.delete();
    run(4'b1010, 4);
    chk("fair_count", 32'(glog.size()), 32'd4);
    for (int k = 0; k < glog.size(); k++)
      chk("fair_order", 32'(glog[k]), (k % 2 == 0) ? 32'd1 : 32'd3);
    idle(10);

    // Drain during contention; grants 0,1,2,3,0 leave the pointer at 1
    run('1, 5);
    drain = 1'b1;
    bus.req_valid = '1;
    done = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      step();
      if (!busy) begin
        done = 1'b1;
        chk("busy_fall_cycle", 32'(cyc), 32'(last_grant_cyc + int'(CONV_LAT) + 2));
      end
    end
    if (!done) begin
      n_chk++;
      $display("FAIL drain_timeout: busy still high after 30 cycles");
    end
    drain = 1'b0;
    glog.delete();
    run('1, 2);
    chk("resume_count", 32'(glog.size()), 32'd2);
    if (glog.size() >= 2) begin
      chk("resume_first", 32'(glog[0]), 32'd1);
      chk("resume_second", 32'(glog[1]), 32'd2);
    end
    idle(10);

    // Reset with three operations in flight
    run(4'b0111, 3);
    chk("pre_rst_inflight", 32'(inflight_cnt), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("post_rst_conv_in", conv_in, 32'd0);
    chk("post_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("post_rst_resp_data", bus.resp_data, 32'd0);
    chk("post_rst_resp_id", 32'(bus.resp_id), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_inflight", 32'(inflight_cnt), 32'd0);
    stray_before = n_stray;
    idle(12);
    chk("no_stale_resp", 32'(n_stray), 32'(stray_before));
    glog.delete();
    run('1, 1);
    chk("post_rst_grant_count", 32'(glog.size()), 32'd1);
    if (glog.size() >= 1) chk("post_rst_ptr", 32'(glog[0]), 32'd0);
    idle(10);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
